// File: rtl/cdce62002_spi_writer_pkg.sv
// Shared constants for the CDCE62002 SPI register writer: word layout, register
// addresses, default register images and the writer FSM state type.
package cdce62002_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned BIT_CNT_W = 5;
  localparam int unsigned PHASE_W   = 8;

  localparam logic [ADDR_W-1:0] REG0_ADDR = 4'h0;
  localparam logic [ADDR_W-1:0] REG1_ADDR = 4'h1;
  localparam logic [ADDR_W-1:0] REG2_ADDR = 4'h2;
  localparam logic [ADDR_W-1:0] READ_CMD  = 4'hE;

  // Power-up images; the low nibble of each image is its own register address.
  localparam logic [WORD_W-1:0] REG0_DEFAULT = 32'h8184_0320;
  localparam logic [WORD_W-1:0] REG1_DEFAULT = 32'h6886_0321;
  localparam logic [WORD_W-1:0] REG2_DEFAULT = 32'h0000_05F2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    GAP
  } state_e;

  function automatic logic [WORD_W-1:0] make_word(input logic [WORD_W-ADDR_W-1:0] payload,
                                                  input logic [ADDR_W-1:0]        addr);
    return {payload, addr};
  endfunction

endpackage

// File: rtl/cdce62002_spi_writer_phase_timer.sv
// Reloadable down-counter that paces every FSM state; tc_o is high while the
// count sits at zero, i.e. on the last cycle of the current state.
module spi_phase_timer
  import cdce62002_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               reload_i,
  input  logic [PHASE_W-1:0] reload_val_i,
  output logic               tc_o
);

  logic [PHASE_W-1:0] cnt_q;
  logic [PHASE_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (reload_i) begin
      cnt_d = reload_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/cdce62002_spi_writer.sv
// Serialises one 32-bit CDCE62002 word LSB first and latches it with a rising
// spi_cs_INV. Optional MISO capture is enabled by defining PLL_SPI_READBACK_EN.
module cdce62002_spi_writer
  import cdce62002_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 8
) (
  input  logic              sysclk,
  input  logic              reset_INV,
  input  logic              start,
  input  logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              spi_clk,
  output logic              spi_mosi,
  output logic              spi_cs_INV,
  input  logic              spi_miso,
  output logic [WORD_W-1:0] rd_data
);

  localparam logic [PHASE_W-1:0] DIV_RELOAD = PHASE_W'(CLK_DIV - 1);
  localparam logic [PHASE_W-1:0] GAP_RELOAD = PHASE_W'(CS_GAP - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WORD_W - 1);

  state_e               state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0]    shift_q, shift_d;
  logic                 done_q, done_d;

  logic                 phase_tc;
  logic                 phase_reload;
  logic [PHASE_W-1:0]   phase_reload_val;

  // Every state change restarts the phase count, so each state owns a full period.
  assign phase_reload     = (state_d != state_q);
  assign phase_reload_val = (state_d == GAP) ? GAP_RELOAD : DIV_RELOAD;

  spi_phase_timer u_phase_timer (
    .clk_i        (sysclk),
    .rst_ni       (reset_INV),
    .reload_i     (phase_reload),
    .reload_val_i (phase_reload_val),
    .tc_o         (phase_tc)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = wr_data;
          bit_cnt_d = '0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (phase_tc) state_d = SHIFT_HI;
      end
      SHIFT_HI: begin
        // Advancing the data on the falling spi_clk keeps MOSI stable across the rise.
        if (phase_tc) begin
          shift_d = {1'b0, shift_q[WORD_W-1:1]};
          state_d = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (phase_tc) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = GAP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            state_d   = SHIFT_HI;
          end
        end
      end
      GAP: begin
        if (phase_tc) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      done_q    <= done_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign spi_clk    = (state_q == SHIFT_HI);
  assign spi_cs_INV = !((state_q == SETUP) || (state_q == SHIFT_HI) || (state_q == SHIFT_LO));
  assign spi_mosi   = spi_cs_INV ? 1'b0 : shift_q[0];

`ifdef PLL_SPI_READBACK_EN
  logic [WORD_W-1:0] cap_q, cap_d;
  logic [WORD_W-1:0] rd_q, rd_d;

  // MISO is taken at the end of the high phase; the word is published with done.
  always_comb begin
    cap_d = cap_q;
    rd_d  = rd_q;
    if ((state_q == SHIFT_HI) && phase_tc) cap_d = {spi_miso, cap_q[WORD_W-1:1]};
    if ((state_q == GAP) && phase_tc)      rd_d  = cap_q;
  end

  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      cap_q <= '0;
      rd_q  <= '0;
    end else begin
      cap_q <= cap_d;
      rd_q  <= rd_d;
    end
  end

  assign rd_data = rd_q;
`else
  logic unused_miso;
  assign unused_miso = spi_miso;
  assign rd_data     = '0;
`endif

endmodule
